// File: rtl/oflow_registration_set_sequencer_if.sv
// Signal bundle between the core registration FSM, the set sequencer and the score-calc engine array.
interface oflow_registration_set_sequencer_if #(
   parameter int NUM_CH  = 2,
   parameter int SET_W   = 5,
   parameter int FRAME_W = 10
);
   logic [FRAME_W-1:0]      frame_num;
   logic [SET_W-1:0]        num_of_sets;
   logic                    start_registration;
   logic                    not_start_registration;
   logic [NUM_CH-1:0]       start_score_calc;
   logic [NUM_CH*SET_W-1:0] ch_set_idx;
   logic [NUM_CH-1:0]       done_score_calc;
   logic [SET_W-1:0]        counter_of_sets;
   logic [SET_W-1:0]        sets_done;
   logic                    busy;
   logic                    done_registration;
   logic                    aborted;
   logic                    err_spurious_done;
   logic                    timeout_flag;

   // core + engine side
   modport master (
      output frame_num, num_of_sets, start_registration, not_start_registration, done_score_calc,
      input  start_score_calc, ch_set_idx, counter_of_sets, sets_done, busy,
             done_registration, aborted, err_spurious_done, timeout_flag
   );

   // sequencer side
   modport slave (
      input  frame_num, num_of_sets, start_registration, not_start_registration, done_score_calc,
      output start_score_calc, ch_set_idx, counter_of_sets, sets_done, busy,
             done_registration, aborted, err_spurious_done, timeout_flag
   );
endinterface

// File: rtl/oflow_registration_set_sequencer.sv
// Dispatches the frame's sets across NUM_CH score-calc engines and tracks completion per channel.
// Optional per-channel watchdog enabled by defining OFLOW_REG_SEQ_TIMEOUT_EN.
module oflow_registration_set_sequencer #(
   parameter int NUM_CH      = 2,
   parameter int SET_W       = 5,
   parameter int FRAME_W     = 10,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset_N,
   oflow_registration_set_sequencer_if.slave bus
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DISPATCH = 2'd1;
   localparam logic [1:0] S_DRAIN    = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   if (NUM_CH < 1 || NUM_CH > 8 || SET_W < 1 || FRAME_W < 1 || TIMEOUT_CYC < 1) begin : g_param_err
      $error("oflow_registration_set_sequencer: parameter out of range");
   end

   logic [1:0]                    state_q, state_d;
   logic [SET_W-1:0]              num_q, cnt_q, done_cnt_q, inc;
   logic [NUM_CH-1:0]             ch_busy_q, free, grant, done_in, done_hit, to_hit, fin;
   logic [NUM_CH-1:0][SET_W-1:0]  ch_idx_q, idx_out;
   logic                          err_q, to_q, abort, start_ok, spurious;

   assign abort    = bus.not_start_registration && (state_q != S_IDLE);
   assign start_ok = (state_q == S_IDLE) && bus.start_registration && (bus.frame_num != '0);
   assign done_in  = bus.done_score_calc;
   assign done_hit = done_in & ch_busy_q;
   assign spurious = |(done_in & ~ch_busy_q);
   assign fin      = done_hit | to_hit;

   // Lowest free channel via two's-complement bit isolation; uses registered busy so a
   // channel freed this cycle is only eligible next cycle.
   assign free = ~ch_busy_q;
   always_comb begin
      grant = '0;
      if (state_q == S_DISPATCH && !abort && cnt_q < num_q)
         grant = free & (~free + NUM_CH'(1));
   end

   always_comb begin
      inc = '0;
      for (int i = 0; i < NUM_CH; i++)
         inc = inc + SET_W'(fin[i]);
   end

   always_comb begin
      idx_out = ch_idx_q;
      for (int i = 0; i < NUM_CH; i++)
         if (grant[i]) idx_out[i] = cnt_q;
   end

`ifdef OFLOW_REG_SEQ_TIMEOUT_EN
   localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [NUM_CH-1:0][TW-1:0] age_q;

   // A done in the same cycle wins over the watchdog.
   always_comb begin
      to_hit = '0;
      for (int i = 0; i < NUM_CH; i++)
         to_hit[i] = ch_busy_q[i] && !done_in[i] && !abort && (age_q[i] == TO_LAST);
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         age_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if (grant[i] || !ch_busy_q[i]) age_q[i] <= '0;
            else                           age_q[i] <= age_q[i] + TW'(1);
      end
   end
`else
   assign to_hit = '0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start_ok) state_d = (bus.num_of_sets == '0) ? S_DONE : S_DISPATCH;
         S_DISPATCH: if (cnt_q == num_q) state_d = S_DRAIN;
         S_DRAIN:    if (ch_busy_q == '0 && done_cnt_q == num_q) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         cnt_q      <= '0;
         done_cnt_q <= '0;
         ch_busy_q  <= '0;
         ch_idx_q   <= '0;
         err_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok)      err_q <= 1'b0;
         else if (spurious) err_q <= 1'b1;
         if (start_ok)      to_q  <= 1'b0;
         else if (|to_hit)  to_q  <= 1'b1;

         if (abort) begin
            cnt_q      <= '0;
            done_cnt_q <= '0;
            ch_busy_q  <= '0;
         end else if (start_ok) begin
            num_q      <= bus.num_of_sets;
            cnt_q      <= '0;
            done_cnt_q <= '0;
         end else begin
            // grant only targets idle lanes and fin only busy ones, so they never collide
            ch_busy_q  <= (ch_busy_q & ~fin) | grant;
            done_cnt_q <= done_cnt_q + inc;
            if (|grant) cnt_q <= cnt_q + SET_W'(1);
            for (int i = 0; i < NUM_CH; i++)
               if (grant[i]) ch_idx_q[i] <= cnt_q;
         end
      end
   end

   assign bus.start_score_calc  = grant;
   assign bus.ch_set_idx        = idx_out;
   assign bus.counter_of_sets   = cnt_q;
   assign bus.sets_done         = done_cnt_q;
   assign bus.busy              = (state_q != S_IDLE);
   assign bus.done_registration = (state_q == S_DONE) && !bus.not_start_registration;
   assign bus.aborted           = abort;
   assign bus.err_spurious_done = err_q;
   assign bus.timeout_flag      = to_q;

endmodule
